// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode mnemonics and the controller state.
package definitions;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_NEG = 4'h6,
        OP_EQ  = 4'h7,
        OP_LT  = 4'h8,
        OP_SHL = 4'h9,
        OP_SHR = 4'hA
    } op_mne;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational W-bit ALU; unlisted opcodes yield zero.
module alu
    import definitions::*;
#(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic [Ops-1:0] op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [W-1:0]   y_o
);

    localparam int SW = (W > 1) ? $clog2(W) : 1;

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NOT:  y_o = ~a_i;
            OP_NEG:  y_o = '0 - a_i;
            OP_EQ:   y_o = {{(W-1){1'b0}}, (a_i == b_i)};
            OP_LT:   y_o = {{(W-1){1'b0}}, (a_i < b_i)};
            OP_SHL:  y_o = a_i << b_i[SW-1:0];
            OP_SHR:  y_o = a_i >> b_i[SW-1:0];
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: grant, execute, hold result until ack.
module alu_arbiter
    import definitions::*;
#(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Req0,
    input  logic           Req1,
    input  logic [Ops-1:0] Op0,
    input  logic [Ops-1:0] Op1,
    input  logic [W-1:0]   InA0,
    input  logic [W-1:0]   InB0,
    input  logic [W-1:0]   InA1,
    input  logic [W-1:0]   InB1,
    output logic           Gnt0,
    output logic           Gnt1,
    output logic           Vld0,
    output logic           Vld1,
    input  logic           Ack0,
    input  logic           Ack1,
    output logic [W-1:0]   Result,
    output logic           Zero,
    output logic           Busy
);

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [Ops-1:0] op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic           zero_q, zero_d;
    logic [W-1:0]   alu_y;
    logic           gnt0, gnt1, win;

    alu #(.W(W), .Ops(Ops)) u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    // On a tie the requester not served last wins.
                    win     = (Req0 && Req1) ? ~last_q : Req1;
                    gnt0    = ~win;
                    gnt1    = win;
                    owner_d = win;
                    last_d  = win;
                    op_d    = win ? Op1  : Op0;
                    a_d     = win ? InA1 : InA0;
                    b_d     = win ? InB1 : InB0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_y;
                zero_d  = (alu_y == '0);
                state_d = DONE;
            end
            DONE: begin
                if (owner_q ? Ack1 : Ack0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    // Grants are suppressed while reset is held so nothing is accepted in that cycle.
    assign Gnt0   = gnt0 && Reset_n;
    assign Gnt1   = gnt1 && Reset_n;
    assign Vld0   = (state_q == DONE) && !owner_q;
    assign Vld1   = (state_q == DONE) &&  owner_q;
    assign Busy   = (state_q != IDLE);
    assign Result = res_q;
    assign Zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode table plus arbitration, stall and reset sequences.
module tb_alu_arbiter;
    import definitions::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Req0, Req1, Ack0, Ack1;
    logic [3:0] Op0, Op1;
    logic [7:0] InA0, InB0, InA1, InB1;
    logic       Gnt0, Gnt1, Vld0, Vld1, Zero, Busy;
    logic [7:0] Result;

    int n_chk = 0;
    int n_err = 0;

    alu_arbiter #(.W(8), .Ops(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .InA0(InA0), .InB0(InB0), .InA1(InA1), .InB1(InB1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Vld0(Vld0), .Vld1(Vld1),
        .Ack0(Ack0), .Ack1(Ack1),
        .Result(Result), .Zero(Zero), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
    } vec_t;

    vec_t vt[15];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int who, input logic r, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        if (who == 0) begin
            Req0 = r; Op0 = op; InA0 = a; InB0 = b;
        end else begin
            Req1 = r; Op1 = op; InA1 = a; InB1 = b;
        end
    endtask

    task automatic set_ack(input int who, input logic v);
        if (who == 0) Ack0 = v; else Ack1 = v;
    endtask

    initial begin
        vt[0]  = '{OP_ADD, 8'd200, 8'd100, 8'd44,  1'b0};
        vt[1]  = '{OP_SUB, 8'd5,   8'd5,   8'd0,   1'b1};
        vt[2]  = '{OP_SUB, 8'd3,   8'd5,   8'd254, 1'b0};
        vt[3]  = '{OP_AND, 8'hF0,  8'h3C,  8'h30,  1'b0};
        vt[4]  = '{OP_OR,  8'hF0,  8'h0F,  8'hFF,  1'b0};
        vt[5]  = '{OP_XOR, 8'hAA,  8'hAA,  8'h00,  1'b1};
        vt[6]  = '{OP_NOT, 8'h0F,  8'h00,  8'hF0,  1'b0};
        vt[7]  = '{OP_EQ,  8'd5,   8'd5,   8'd1,   1'b0};
        vt[8]  = '{OP_NEG, 8'd1,   8'd0,   8'd255, 1'b0};
        vt[9]  = '{OP_EQ,  8'd5,   8'd6,   8'd0,   1'b1};
        vt[10] = '{OP_LT,  8'd3,   8'd4,   8'd1,   1'b0};
        vt[11] = '{OP_SHL, 8'h81,  8'd1,   8'h02,  1'b0};
        vt[12] = '{OP_SHR, 8'h81,  8'd1,   8'h40,  1'b0};
        vt[13] = '{4'hF,   8'h12,  8'h34,  8'h00,  1'b1};
        vt[14] = '{4'hB,   8'hFF,  8'hFF,  8'h00,  1'b1};

        Reset_n = 1'b0;
        Req0 = 0; Req1 = 0; Ack0 = 0; Ack1 = 0;
        Op0 = 0; Op1 = 0; InA0 = 0; InB0 = 0; InA1 = 0; InB1 = 0;
        tick; tick;
        chk("rst_gnt0", Gnt0, 0);
        chk("rst_gnt1", Gnt1, 0);
        chk("rst_vld0", Vld0, 0);
        chk("rst_vld1", Vld1, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_result", Result, 0);
        chk("rst_zero", Zero, 0);
        Reset_n = 1'b1;

        // Both requesting from reset: grants alternate 0,1,0,1.
        drive(0, 1, OP_ADD, 8'd1, 8'd2);
        drive(1, 1, OP_ADD, 8'd10, 8'd20);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_gnt0", Gnt0, (k % 2 == 0));
            chk("tie_gnt1", Gnt1, (k % 2 == 1));
            tick; tick;
            chk("tie_vld", (k % 2 == 0) ? Vld0 : Vld1, 1);
            chk("tie_res", Result, (k % 2 == 0) ? 8'd3 : 8'd30);
            set_ack(k % 2, 1);
            tick;
            set_ack(k % 2, 0);
        end

        // Withheld Ack0 with Req1 pending and a stray Ack1.
        drive(0, 1, OP_ADD, 8'd7, 8'd9);
        drive(1, 1, OP_SUB, 8'd9, 8'd7);
        #1;
        chk("stall_gnt0", Gnt0, 1);
        tick; tick;
        Ack1 = 1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stall_vld0", Vld0, 1);
            chk("stall_vld1", Vld1, 0);
            chk("stall_gnt1", Gnt1, 0);
            chk("stall_busy", Busy, 1);
            chk("stall_res", Result, 8'd16);
            tick;
        end
        Ack1 = 0; Ack0 = 1;
        #1;
        chk("stall_vld0_ack", Vld0, 1);
        tick;
        Ack0 = 0;
        #1;
        chk("stall_after_gnt1", Gnt1, 1);
        chk("stall_after_gnt0", Gnt0, 0);
        chk("stall_after_busy", Busy, 0);
        tick;
        Req0 = 0; Req1 = 0;
        tick;
        chk("stall_vld1_late", Vld1, 1);
        chk("stall_res1", Result, 8'd2);
        Ack1 = 1;
        tick;
        Ack1 = 0;

        // Opcode table, alternating requesters.
        for (int i = 0; i < 15; i++) begin
            int who;
            who = i % 2;
            drive(who, 1, vt[i].op, vt[i].a, vt[i].b);
            #1;
            chk("vec_gnt", (who == 0) ? Gnt0 : Gnt1, 1);
            chk("vec_gnt_other", (who == 0) ? Gnt1 : Gnt0, 0);
            tick;
            drive(who, 0, 4'h0, 8'h00, 8'h00);
            chk("vec_exec_busy", Busy, 1);
            chk("vec_exec_vld", {Vld1, Vld0}, 0);
            tick;
            chk("vec_vld", (who == 0) ? Vld0 : Vld1, 1);
            chk("vec_res", Result, vt[i].y);
            chk("vec_zero", Zero, vt[i].z);
            set_ack(who, 1);
            tick;
            set_ack(who, 0);
            chk("vec_idle_busy", Busy, 0);
            chk("vec_idle_hold", Result, vt[i].y);
        end

        // Reset during EXEC abandons the operation.
        drive(0, 1, OP_ADD, 8'd1, 8'd2);
        tick;
        Req0 = 0;
        tick;
        chk("pre_res", Result, 8'd3);
        Ack0 = 1;
        tick;
        Ack0 = 0;
        drive(0, 1, OP_ADD, 8'd4, 8'd4);
        #1;
        chk("pre_gnt0", Gnt0, 1);
        tick;
        Reset_n = 0;
        drive(1, 1, OP_ADD, 8'd50, 8'd50);
        tick;
        chk("mid_rst_gnt", {Gnt1, Gnt0}, 0);
        chk("mid_rst_vld", {Vld1, Vld0}, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_res", Result, 0);
        chk("mid_rst_zero", Zero, 0);
        Reset_n = 1;
        #1;
        chk("post_rst_gnt0", Gnt0, 1);
        chk("post_rst_gnt1", Gnt1, 0);
        tick;
        Req0 = 0; Req1 = 0;
        chk("post_rst_novld", {Vld1, Vld0}, 0);
        tick;
        chk("post_rst_vld0", Vld0, 1);
        chk("post_rst_res", Result, 8'd8);
        Ack0 = 1;
        tick;
        Ack0 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, meaning datapath width (operands and result).
REQ-002 SHALL have parameter Ops, default 4, meaning opcode width (matches op_mne in definitions).
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports Req0 / Req1, input, 1, requester 0/1 asks for one ALU operation; held until granted.
REQ-006 SHALL have ports Op0 / Op1, input, Ops, requester opcode; sampled only in the grant cycle.
REQ-007 SHALL have ports InA0, InB0 / InA1, InB1, input, W, requester operands; sampled only in the grant cycle.
REQ-008 SHALL have ports Gnt0 / Gnt1, output, 1, one-cycle pulse: request accepted and operands captured.
REQ-009 SHALL have ports Vld0 / Vld1, output, 1, result for that requester is valid on Result/Zero.
REQ-010 SHALL have ports Ack0 / Ack1, input, 1, requester consumes the result; meaningful only while its Vld is high.
REQ-011 SHALL have port Result, output, W, registered ALU output of the current operation.
REQ-012 SHALL have port Zero, output, 1, registered flag: Result == 0.
REQ-013 SHALL have port Busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-015 IDLE: no request -> stay; any request -> assert the winner's Gnt for that cycle, latch its Op/InA/InB and owner id, go to EXEC.
REQ-016 Only one Gnt SHALL be high in any cycle, and only in IDLE.
REQ-017 Arbitration SHALL be round-robin: single request wins outright; with both requesting, the requester not served last wins.
REQ-018 The last-served pointer SHALL update only when a grant is issued.
REQ-019 EXEC: drive the ALU from the latched operand/opcode registers, register its output into Result and Zero, go to DONE.
REQ-020 DONE: hold the owner's Vld high with Result/Zero stable; on the owner's Ack -> IDLE next cycle; no Ack -> stay.
REQ-021 Latency SHALL be exactly 2 cycles from the Gnt cycle to the first Vld cycle; minimum issue interval 3 cycles.
REQ-022 A non-owner Ack, or any Ack outside DONE, SHALL be ignored.
REQ-023 A request arriving while Busy SHALL wait; it may not be dropped, and its Gnt comes no earlier than the IDLE cycle after the Ack.
REQ-024 Opcodes outside the defined op_mne set SHALL produce Result = 0, Zero = 1 (ALU default), with normal handshake.
REQ-025 Arithmetic SHALL be W bits with wrap-around and no carry output (e.g. ADD 200 + 100 = 44).
REQ-026 Result and Zero SHALL hold their last values in IDLE.

Reset
REQ-027 When Reset_n is low at a clock edge, the block SHALL enter IDLE and clear Gnt0/1, Vld0/1, Result, Zero, Busy and the operand registers to 0.
REQ-028 After reset, the last-served pointer SHALL be requester 1, so requester 0 wins the first tie.
REQ-029 Reset in EXEC or DONE SHALL abandon the operation with no Vld ever issued for it.

Structure
REQ-030 The FSM state enum (IDLE, EXEC, DONE) SHALL be added to package definitions next to op_mne.
REQ-031 The block SHALL instantiate the existing combinational ALU as its only sub-module; it adds no arithmetic of its own beyond the Zero compare.

Verification
REQ-032 Req0 with ADD, InA0=200, InB0=100 -> Gnt0 at cycle t, Vld0 at t+2, Result=44, Zero=0.
REQ-033 Req0 and Req1 both high from reset -> Gnt0 first; after Ack0 -> Gnt1; further ties alternate.
REQ-034 Req1 with EQ, 5, 5 -> Result=1; then Req1 with NEG, 1 -> Result=255, Zero=0.
REQ-035 Ack0 withheld 10 cycles with Req1 high -> Vld0, Result, Busy stable and no Gnt1 until the cycle after Ack0; Ack1 meanwhile ignored.
REQ-036 Reset_n low during EXEC -> next cycle all outputs 0 and state IDLE; with both requesting afterwards, requester 0 wins.
REQ-037 Undefined opcode 4'hF, any operands -> Result=0, Zero=1, Vld issued after the normal 2-cycle latency.
